mont_cmd_ctrl: RTL
==================

Name: mont_cmd_ctrl

Overview:
Command/data controller between the ARM-facing command/data ports and one Montgomery multiplier core. It decodes 32-bit commands and captures packed A|B and M operands from 1024-bit transfers. It launches the core, captures the result and returns it. Every command is closed by a done/done_read handshake, which is the protocol the host bench drives.

Parameters:
DATA_WIDTH, 1024, width of the ARM data bus
OP_WIDTH, 512, operand/result width of the Montgomery core (DATA_WIDTH = 2*OP_WIDTH)

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
arm_to_fpga_cmd  in  32  command code
arm_to_fpga_cmd_valid  in  1  command strobe
fpga_to_arm_done  out  1  command complete, held until read
fpga_to_arm_done_read  in  1  host acknowledges done
arm_to_fpga_data_valid  in  1  host input data valid
arm_to_fpga_data_ready  out  1  controller accepts input data
arm_to_fpga_data  in  DATA_WIDTH  host input data
fpga_to_arm_data_valid  out  1  output data valid
fpga_to_arm_data_ready  in  1  host ready for output
fpga_to_arm_data  out  DATA_WIDTH  output data
mont_start  out  1  one-cycle start pulse to core
mont_soft_reset  out  1  one-cycle active-high core reset pulse
mont_a, mont_b, mont_m  out  OP_WIDTH each  registered operands
mont_done  in  1  core completion, sampled each cycle (pulse or level)
mont_result  in  OP_WIDTH  core result, valid while mont_done=1
compute_cycles  out  32  cycles from mont_start to mont_done of last compute
leds  out  4  {err, state[2:0]}

Behaviour:
- Reset (async, resetn=0): state=IDLE. All outputs 0: done, ready, valid, start, soft_reset, operands, result register, compute_cycles, flags ab_loaded/m_loaded/err.
- Commands accepted only in IDLE when cmd_valid=1; cmd_valid in any other state is ignored (no queuing).
  - 0x1 -> RX_AB
  - 0x2 -> RX_M
  - 0x4 -> START if ab_loaded&m_loaded, else err=1 -> DONE
  - 0x8 -> TX
  - 0x9 -> SRST
  - any other code -> err=1 -> DONE
- err is cleared on acceptance of every valid command, before it is re-evaluated.
- RX_AB / RX_M: data_ready=1 (registered, rises the cycle after entry). Transfer on valid&ready.
  - RX_AB: mont_a<=data[1023:512], mont_b<=data[511:0], ab_loaded<=1.
  - RX_M: mont_m<=data[511:0], m_loaded<=1. Upper half is ignored, and its nonzero content is not an error.
  - Next cycle: ready=0, state=DONE. Exactly one word is taken per command.
- START: mont_start=1 for exactly one cycle, cycle counter cleared, -> WAIT.
- WAIT: counter increments each cycle. On mont_done=1: result register<=mont_result, compute_cycles<=counter+1, -> DONE.
  - mont_done high in the START cycle itself is ignored.
  - No timeout; a hung core is left in WAIT until resetn.
- TX: fpga_to_arm_data = {OP_WIDTH'b0, result register} is held stable. fpga_to_arm_data_valid=1 from the cycle after entry until valid&ready, then valid=0 and state=DONE.
  - Before any compute, TX returns 0.
  - Repeated TX returns the same value.
- SRST: mont_soft_reset=1 for one cycle. Operands, ab_loaded, m_loaded, result register and compute_cycles are cleared. -> DONE.
- DONE: fpga_to_arm_done=1 (registered) until done_read=1 is sampled. Then done=0 and state=IDLE on the same edge. A cmd_valid in that same cycle is ignored.
- leds[2:0] encoding: IDLE=0, RX_AB=1, RX_M=2, START=3, WAIT=4, TX=5, SRST=6, DONE=7. leds[3]=err.
- resetn low mid-operation: immediate return to reset state. The core is not pulsed; the host must also reset the core.

Test Plan:
- Reset, then cmd 0x8 and read: output=0, done asserted, leds=4'b0111 in DONE, 4'b0000 after done_read.
- Cmd 0x1 with data {512'h3,512'h5}, cmd 0x2 with data 512'h7 in the low half and 0xFF.. in the upper half: mont_a=3, mont_b=5, mont_m=7, ready pulses once per command.
- Load as above; cmd 0x4 with a core model that raises mont_done 10 cycles after start, result=1: mont_start pulses once, compute_cycles=10, then cmd 0x8 returns 1024'h1.
- After reset, cmd 0x4 without loading M: no mont_start, done asserted, leds[3]=1. Next valid command 0x2 clears err.
- Cmd 0x9 after a compute: mont_soft_reset one-cycle pulse, subsequent cmd 0x8 returns 0, and cmd 0x4 flags err. Cmd 0x3 (unsupported): err=1, done.
- Hold fpga_to_arm_data_ready=0 for 20 cycles in TX: valid stays 1 and data stays stable. Pulse cmd_valid during WAIT: ignored. Assert resetn=0 during WAIT: all outputs 0 asynchronously.

Source files
------------

// File: rtl/mont_cmd_ctrl.sv
// mont_cmd_ctrl: ARM command/data front-end driving a single Montgomery multiplier core.
// Rev 1.0
`default_nettype none

module mont_cmd_ctrl #(
  parameter int DATA_WIDTH = 1024,
  parameter int OP_WIDTH   = 512
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           arm_to_fpga_cmd,
  input  logic                  arm_to_fpga_cmd_valid,
  output logic                  fpga_to_arm_done,
  input  logic                  fpga_to_arm_done_read,
  input  logic                  arm_to_fpga_data_valid,
  output logic                  arm_to_fpga_data_ready,
  input  logic [DATA_WIDTH-1:0] arm_to_fpga_data,
  output logic                  fpga_to_arm_data_valid,
  input  logic                  fpga_to_arm_data_ready,
  output logic [DATA_WIDTH-1:0] fpga_to_arm_data,
  output logic                  mont_start,
  output logic                  mont_soft_reset,
  output logic [OP_WIDTH-1:0]   mont_a,
  output logic [OP_WIDTH-1:0]   mont_b,
  output logic [OP_WIDTH-1:0]   mont_m,
  input  logic                  mont_done,
  input  logic [OP_WIDTH-1:0]   mont_result,
  output logic [31:0]           compute_cycles,
  output logic [3:0]            leds
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RX_AB = 3'd1,
    S_RX_M  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_TX    = 3'd5,
    S_SRST  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [31:0] C_CMD_AB    = 32'h1;
  localparam logic [31:0] C_CMD_M     = 32'h2;
  localparam logic [31:0] C_CMD_START = 32'h4;
  localparam logic [31:0] C_CMD_TX    = 32'h8;
  localparam logic [31:0] C_CMD_SRST  = 32'h9;

  state_t                r_state, w_next;
  logic                  w_cmd_bad;
  logic                  w_cmd_take, w_rx_xfer, w_tx_xfer;
  logic                  r_ready, r_tx_valid, r_done, r_start, r_srst;
  logic                  r_ab_loaded, r_m_loaded, r_err;
  logic [OP_WIDTH-1:0]   r_a, r_b, r_m, r_result;
  logic [31:0]           r_count, r_cycles;

  assign w_cmd_take = (r_state == S_IDLE) && arm_to_fpga_cmd_valid;
  // r_ready is only ever high inside the two receive states
  assign w_rx_xfer  = arm_to_fpga_data_valid && r_ready;
  assign w_tx_xfer  = r_tx_valid && fpga_to_arm_data_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_cmd_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          case (arm_to_fpga_cmd)
            C_CMD_AB:    w_next = S_RX_AB;
            C_CMD_M:     w_next = S_RX_M;
            C_CMD_START: begin
              if (r_ab_loaded && r_m_loaded) begin
                w_next = S_START;
              end else begin
                w_cmd_bad = 1'b1;
                w_next    = S_DONE;
              end
            end
            C_CMD_TX:    w_next = S_TX;
            C_CMD_SRST:  w_next = S_SRST;
            default: begin
              w_cmd_bad = 1'b1;
              w_next    = S_DONE;
            end
          endcase
        end
      end
      S_RX_AB, S_RX_M: if (w_rx_xfer) w_next = S_DONE;
      S_START:         w_next = S_WAIT;
      S_WAIT:          if (mont_done) w_next = S_DONE;
      S_TX:            if (w_tx_xfer) w_next = S_DONE;
      S_SRST:          w_next = S_DONE;
      S_DONE:          if (fpga_to_arm_done_read) w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready     <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_start     <= 1'b0;
      r_srst      <= 1'b0;
      r_ab_loaded <= 1'b0;
      r_m_loaded  <= 1'b0;
      r_err       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_m         <= '0;
      r_result    <= '0;
      r_count     <= '0;
      r_cycles    <= '0;
    end else begin
      r_ready    <= ((r_state == S_RX_AB) || (r_state == S_RX_M)) && !w_rx_xfer;
      r_tx_valid <= (r_state == S_TX) && !w_tx_xfer;
      r_start    <= (w_next == S_START);
      r_srst     <= (w_next == S_SRST);
      r_done     <= (w_next == S_DONE);

      if (w_cmd_take) r_err <= w_cmd_bad;

      if ((r_state == S_RX_AB) && w_rx_xfer) begin
        r_a         <= arm_to_fpga_data[DATA_WIDTH-1:OP_WIDTH];
        r_b         <= arm_to_fpga_data[OP_WIDTH-1:0];
        r_ab_loaded <= 1'b1;
      end
      if ((r_state == S_RX_M) && w_rx_xfer) begin
        r_m        <= arm_to_fpga_data[OP_WIDTH-1:0];
        r_m_loaded <= 1'b1;
      end

      // Counter holds cycles already spent in WAIT; the done cycle itself adds one
      if (r_state == S_START)     r_count <= '0;
      else if (r_state == S_WAIT) r_count <= r_count + 32'd1;

      if ((r_state == S_WAIT) && mont_done) begin
        r_result <= mont_result;
        r_cycles <= r_count + 32'd1;
      end

      if (r_state == S_SRST) begin
        r_a         <= '0;
        r_b         <= '0;
        r_m         <= '0;
        r_result    <= '0;
        r_cycles    <= '0;
        r_ab_loaded <= 1'b0;
        r_m_loaded  <= 1'b0;
      end
    end
  end

  assign fpga_to_arm_done       = r_done;
  assign arm_to_fpga_data_ready = r_ready;
  assign fpga_to_arm_data_valid = r_tx_valid;
  assign fpga_to_arm_data       = {{(DATA_WIDTH-OP_WIDTH){1'b0}}, r_result};
  assign mont_start             = r_start;
  assign mont_soft_reset        = r_srst;
  assign mont_a                 = r_a;
  assign mont_b                 = r_b;
  assign mont_m                 = r_m;
  assign compute_cycles         = r_cycles;
  assign leds                   = {r_err, r_state};

endmodule

`default_nettype wire
